// File: rtl/ternary_pkg.sv
// Shared balanced-ternary trit encoding, plus conversions between trit codes
// and small signed integers.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_POS  = 2'b10;
  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_NEG  = 2'b01;
  localparam trit_t TRIT_ERR  = 2'b11;

  // The invalid code maps to 0 here; callers must check validity separately.
  function automatic logic signed [2:0] trit_to_int(input trit_t t);
    case (t)
      TRIT_POS: return 3'sb001;
      TRIT_NEG: return 3'sb111;
      default:  return 3'sb000;
    endcase
  endfunction

  function automatic trit_t int_to_trit(input logic signed [2:0] v);
    case (v)
      3'sb001: return TRIT_POS;
      3'sb111: return TRIT_NEG;
      3'sb000: return TRIT_ZERO;
      default: return TRIT_ERR;
    endcase
  endfunction

endpackage

// File: rtl/trit_decode.sv
// Converts an encoded trit into a signed value in -1..+1, and flags the
// reserved invalid code.
module trit_decode
  import ternary_pkg::*;
(
  input  trit_t              code,
  output logic signed [2:0]  val,
  output logic               invalid
);

  assign val     = trit_to_int(code);
  assign invalid = (code == TRIT_ERR);

endmodule

// File: rtl/add_half_te.sv
// Balanced-ternary half adder with registered sum, carry and error flag.
// Each operand pair produces its result one cycle after it is sampled.
module add_half_te
  import ternary_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] c,
  output logic [1:0] cout,
  output logic       err
);

  logic signed [2:0] val_a;
  logic signed [2:0] val_b;
  logic signed [2:0] sum;
  logic              inv_a;
  logic              inv_b;
  trit_t             c_next;
  trit_t             cout_next;
  logic              err_next;

  trit_decode u_dec_a (.code(a), .val(val_a), .invalid(inv_a));
  trit_decode u_dec_b (.code(b), .val(val_b), .invalid(inv_b));

  assign sum = val_a + val_b;

  // A sum of +/-2 folds into an opposite-sign digit plus a carry of the same sign.
  always_comb begin
    c_next    = TRIT_ZERO;
    cout_next = TRIT_ZERO;
    err_next  = 1'b0;
    if (inv_a || inv_b) begin
      c_next   = TRIT_ERR;
      err_next = 1'b1;
    end else begin
      case (sum)
        3'sb110: begin
          c_next    = TRIT_POS;
          cout_next = TRIT_NEG;
        end
        3'sb010: begin
          c_next    = TRIT_NEG;
          cout_next = TRIT_POS;
        end
        default: c_next = int_to_trit(sum);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c    <= TRIT_ZERO;
      cout <= TRIT_ZERO;
      err  <= 1'b0;
    end else begin
      c    <= c_next;
      cout <= cout_next;
      err  <= err_next;
    end
  end

endmodule

// File: tb/tb_add_half_te.sv
// Bench for add_half_te. The stimulus queues hand-computed results; a
// separate monitor checks one result per cycle against that queue.
module tb_add_half_te;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] c;
  logic [1:0] cout;
  logic       err;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       r;
    logic [1:0] c;
    logic [1:0] cout;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  add_half_te dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .cout (cout),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge; the next rising edge samples the inputs.
  task automatic issue(input logic r, input logic [1:0] ta, input logic [1:0] tb,
                       input logic [1:0] ec, input logic [1:0] eco, input logic ee);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    a     = ta;
    b     = tb;
    e.a = ta; e.b = tb; e.r = r; e.c = ec; e.cout = eco; e.err = ee;
    sb.push_back(e);
  endtask

  // Monitor: one result per rising edge once something has been issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (c !== e.c || cout !== e.cout || err !== e.err) begin
          bad++;
          $display("FAIL txn%0d rst_n=%b a=%b b=%b: got c=%b cout=%b err=%b, want c=%b cout=%b err=%b",
                   total, e.r, e.a, e.b, c, cout, err, e.c, e.cout, e.err);
        end else begin
          $display("ok   txn%0d rst_n=%b a=%b b=%b -> c=%b cout=%b err=%b",
                   total, e.r, e.a, e.b, c, cout, err);
        end
      end
    end
  end

  // Valid pairs: a, b, c, cout (hand-derived from the balanced-ternary table).
  logic [7:0] pairs [9] = '{
    8'b10_10_01_10, 8'b10_00_10_00, 8'b10_01_00_00,
    8'b00_10_10_00, 8'b00_00_00_00, 8'b00_01_01_00,
    8'b01_10_00_00, 8'b01_00_01_00, 8'b01_01_10_01
  };

  initial begin
    logic [7:0] p;
    int wait_cycles;
    rst_n = 1'b0;
    a = 2'b00;
    b = 2'b00;

    // Reset held for two edges with +1,+1 applied, then released.
    issue(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
    issue(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
    issue(1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0);

    // Simple sweep.
    issue(1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
    issue(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    issue(1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
    issue(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0);

    // Carry generation.
    issue(1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0);
    issue(1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0);

    // Invalid codes, then recovery.
    issue(1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1);
    issue(1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 1'b1);
    issue(1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1);
    issue(1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);

    // All ordered pairs and their swaps, back to back.
    for (int i = 0; i < 9; i++) begin
      p = pairs[i];
      issue(1'b1, p[7:6], p[5:4], p[3:2], p[1:0], 1'b0);
      issue(1'b1, p[5:4], p[7:6], p[3:2], p[1:0], 1'b0);
    end

    // Single-edge reset pulse in the middle of a +1,+1 stream.
    issue(1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0);
    issue(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
    issue(1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0);
    issue(1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
